// File: rtl/datapath_unit.sv
// Multi-cycle arithmetic unit: ADD/SUB in one cycle,
// MUL/DIV iterate one bit per cycle over latched operands.
module datapath_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [3:0]       opcode,
  input  logic [7:0]       a,
  input  logic [7:0]       b,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             err,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE,
    HOLD
  } state_t;

  state_t     state;
  logic [3:0] op_r;
  logic [7:0] a_r;
  logic [7:0] b_r;
  logic [2:0] cnt;
  logic [15:0] acc;
  logic [7:0] quo;
  logic [7:0] rem;

  logic        is_add;
  logic        is_sub;
  logic        is_mul;
  logic        is_div;
  logic        is_dz;
  logic        last;
  logic [15:0] mul_nx;
  logic [8:0]  trial;
  logic        div_ge;
  logic [7:0]  rem_nx;
  logic [7:0]  quo_nx;
  logic [WIDTH-1:0] res_nx;
  logic        err_nx;

  assign is_add = (op_r == 4'd0);
  assign is_sub = (op_r == 4'd1);
  assign is_mul = (op_r == 4'd2);
  assign is_div = (op_r == 4'd3) && (b_r != 8'd0);
  assign is_dz  = (op_r == 4'd3) && (b_r == 8'd0);
  assign last   = !(is_mul || is_div) || (cnt == 3'd7);

  // shift-add: add a << cnt when multiplier bit cnt is set
  assign mul_nx = b_r[cnt] ? acc + ({8'd0, a_r} << cnt)
                           : acc;

  // restoring division: dividend bits shift out of quo
  assign trial  = {rem, quo[7]};
  assign div_ge = (trial >= {1'b0, b_r});
  assign rem_nx = div_ge ? 8'(trial - {1'b0, b_r})
                         : trial[7:0];
  assign quo_nx = {quo[6:0], div_ge};

  always_comb begin
    res_nx = '0;
    err_nx = 1'b0;
    unique case (1'b1)
      is_add: res_nx = {8'd0, a_r} + {8'd0, b_r};
      is_sub: res_nx = {8'd0, a_r} - {8'd0, b_r};
      is_mul: res_nx = mul_nx;
      is_div: res_nx = {quo_nx, rem_nx};
      is_dz: begin
        res_nx = '1;
        err_nx = 1'b1;
      end
      default: begin
        res_nx = '0;
        err_nx = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      result <= '0;
      done   <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
      cnt    <= '0;
      op_r   <= '0;
      a_r    <= '0;
      b_r    <= '0;
      acc    <= '0;
      quo    <= '0;
      rem    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            op_r  <= opcode;
            a_r   <= a;
            b_r   <= b;
            err   <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            quo   <= a;
            rem   <= '0;
            busy  <= 1'b1;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (last) begin
            result <= res_nx;
            err    <= err_nx;
            done   <= 1'b1;
            state  <= DONE;
          end else begin
            cnt <= cnt + 3'd1;
            acc <= mul_nx;
            quo <= quo_nx;
            rem <= rem_nx;
          end
        end
        DONE: begin
          busy  <= enable;
          state <= enable ? HOLD : IDLE;
        end
        HOLD: begin
          if (!enable) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_datapath_unit.sv
// Scoreboard bench for datapath_unit: driver pushes
// expected results, a monitor checks every done pulse.
module tb_datapath_unit;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [3:0]  opcode;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [15:0] result;
  logic        done;
  logic        err;
  logic        busy;

  int tests;
  int fails;
  int cyc;
  int n_done;

  typedef struct {
    logic [15:0] res;
    logic        err;
    int          due;
    string       name;
  } exp_t;

  exp_t q[$];

  datapath_unit #(.WIDTH(16)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .opcode (opcode),
    .a      (a),
    .b      (b),
    .result (result),
    .done   (done),
    .err    (err),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h",
               nm, act, req);
    end
  endtask

  // Reference: plain arithmetic on the operands
  function automatic logic [16:0] model(
      input logic [3:0] op,
      input logic [7:0] x,
      input logic [7:0] y);
    int xi;
    int yi;
    xi = int'(x);
    yi = int'(y);
    case (op)
      4'd0: return {1'b0, 16'(xi + yi)};
      4'd1: return {1'b0, 16'(xi - yi)};
      4'd2: return {1'b0, 16'(xi * yi)};
      4'd3: begin
        if (yi == 0) return {1'b1, 16'hFFFF};
        return {1'b0, 8'(xi / yi), 8'(xi % yi)};
      end
      default: return {1'b1, 16'h0000};
    endcase
  endfunction

  function automatic int lat(input logic [3:0] op,
                             input logic [7:0] y);
    if (op == 4'd2) return 8;
    if (op == 4'd3 && y != 8'd0) return 8;
    return 1;
  endfunction

  // Monitor: every done pulse must match the head of the queue
  always @(negedge clk) begin
    if (reset && done) begin
      exp_t e;
      n_done++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: result %0h at cycle %0d",
                 result, cyc);
      end else begin
        e = q.pop_front();
        check({e.name, "_result"}, 32'(result), 32'(e.res));
        check({e.name, "_err"}, 32'(err), 32'(e.err));
        check({e.name, "_cycle"}, cyc, e.due);
      end
    end
  end

  task automatic run_op(input logic [3:0] op,
                        input logic [7:0] av,
                        input logic [7:0] bv,
                        input int hold,
                        input int drop,
                        input bit scramble,
                        input string nm);
    int n;
    bit seen;
    logic [16:0] m;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    opcode = op;
    a = av;
    b = bv;
    enable = 1'b1;
    @(posedge clk);
    #1;
    m = model(op, av, bv);
    e.res = m[15:0];
    e.err = m[16];
    e.due = cyc + lat(op, bv);
    e.name = nm;
    q.push_back(e);
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (done) begin
        seen = 1'b1;
      end else begin
        if (scramble) begin
          opcode = 4'($urandom);
          a = 8'($urandom);
          b = 8'($urandom);
        end
        if (n == drop) enable = 1'b0;
      end
    end
    if (!seen) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: no done, expected one", nm);
    end
    if (enable && hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (scramble) begin
          opcode = 4'($urandom);
          a = 8'($urandom);
          b = 8'($urandom);
        end
        check({nm, "_busy_hold"}, 32'(busy), 32'd1);
      end
      enable = 1'b0;
      @(negedge clk);
      check({nm, "_busy_release"}, 32'(busy), 32'd0);
    end
    enable = 1'b0;
  endtask

  initial begin
    int d0;
    logic [3:0] rop;
    tests = 0;
    fails = 0;
    n_done = 0;
    reset = 1'b1;
    enable = 1'b0;
    opcode = '0;
    a = '0;
    b = '0;
    #3 reset = 1'b0;
    #1;
    check("reset_result", 32'(result), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    run_op(4'd0, 8'hFF, 8'h01, 0, 0, 1'b0, "add_ff_01");
    run_op(4'd1, 8'd3, 8'd5, 0, 0, 1'b0, "sub_3_5");
    run_op(4'd2, 8'hFF, 8'hFF, 0, 0, 1'b0, "mul_ff_ff");
    run_op(4'd3, 8'd200, 8'd7, 0, 0, 1'b0, "div_200_7");
    run_op(4'd3, 8'd9, 8'd0, 0, 0, 1'b0, "div_by_zero");
    run_op(4'hF, 8'd1, 8'd2, 20, 0, 1'b0, "bad_op_hold");
    run_op(4'd2, 8'd0, 8'd77, 0, 0, 1'b0, "mul_a0");
    run_op(4'd3, 8'd5, 8'd9, 0, 0, 1'b0, "div_a_lt_b");
    run_op(4'd2, 8'd13, 8'd11, 0, 3, 1'b0, "mul_early_drop");
    run_op(4'd2, 8'd12, 8'd10, 3, 0, 1'b1, "mul_scramble");

    // Abort a MUL with reset while it iterates
    run_op(4'd0, 8'd5, 8'd6, 0, 0, 1'b0, "add_pre_abort");
    @(negedge clk);
    opcode = 4'd2;
    a = 8'd9;
    b = 8'd9;
    enable = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort_result", 32'(result), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    d0 = n_done;
    repeat (12) @(negedge clk);
    check("abort_no_done", n_done, d0);
    run_op(4'd0, 8'd2, 8'd2, 0, 0, 1'b0, "add_after_abort");

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 5));
      if (rop == 4'd5) rop = 4'($urandom_range(4, 15));
      run_op(rop, 8'($urandom),
             ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 4),
             1'($urandom), "rand");
    end

    repeat (4) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
